// File: rtl/branch_btb_predictor_pkg.sv
// Shared types, counter constants and PC index/tag helpers for the branch target buffer.
package branch_pkg;

  localparam int unsigned BTB_XLEN    = 32;
  localparam int unsigned BTB_ENTRIES = 16;
  localparam int unsigned BTB_CTR_W   = 2;
  localparam int unsigned BTB_IDX_W   = $clog2(BTB_ENTRIES);
  localparam int unsigned BTB_TAG_W   = BTB_XLEN - BTB_IDX_W - 2;

  function automatic logic [31:0] ctr_weak_taken(input int unsigned ctr_w);
    return 32'd1 << (ctr_w - 1);
  endfunction

  localparam logic [BTB_CTR_W-1:0] CTR_WEAK_TAKEN = BTB_CTR_W'(ctr_weak_taken(BTB_CTR_W));
  localparam logic [BTB_CTR_W-1:0] CTR_MAX        = '1;

  typedef struct packed {
    logic                 valid;
    logic                 is_jmp;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_XLEN-1:0]  target;
    logic [BTB_CTR_W-1:0] ctr;
  } btb_entry_t;

  // Word-aligned PCs: bits [1:0] never take part in index or tag.
  function automatic logic [63:0] btb_index(input logic [63:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] btb_tag(input logic [63:0] pc, input int unsigned idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/branch_btb_predictor_if.sv
// Lookup / prediction / training / redirect bundle between the branch pipe and the BTB.
interface branch_btb_predictor_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            branch_squash;
  logic            btb_flush;
  logic            lookup_valid;
  logic [XLEN-1:0] lookup_pc;
  logic            pred_valid;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_is_jmp;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_pred_taken;
  logic [XLEN-1:0] upd_pred_target;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output stall, branch_squash, btb_flush, lookup_valid, lookup_pc,
           upd_valid, upd_pc, upd_is_jmp, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  pred_valid, pred_hit, pred_taken, pred_target, mispredict, redirect_pc
  );

  modport slave (
    input  stall, branch_squash, btb_flush, lookup_valid, lookup_pc,
           upd_valid, upd_pc, upd_is_jmp, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output pred_valid, pred_hit, pred_taken, pred_target, mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_btb_predictor_sat_ctr.sv
// Saturating up/down direction counter step (combinational).
module branch_sat_ctr #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] i_ctr,
  input  logic             i_inc,
  output logic [CTR_W-1:0] o_ctr
);
  always_comb begin
    o_ctr = i_ctr;
    if (i_inc) begin
      if (i_ctr != '1) o_ctr = i_ctr + 1'b1;
    end else begin
      if (i_ctr != '0) o_ctr = i_ctr - 1'b1;
    end
  end
endmodule

// File: rtl/branch_btb_predictor.sv
// Direct-mapped BTB with per-entry direction counters: registered prediction, resolve-time training and redirect.
module branch_btb_predictor
  import branch_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_btb_predictor_if.slave  bp
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_weak_taken(CTR_W));

  // Valid bits live apart from the payload so only they carry a reset.
  typedef struct packed {
    logic             is_jmp;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [CTR_W-1:0] ctr;
  } entry_t;

  entry_t             r_tbl [ENTRIES];
  logic [ENTRIES-1:0] r_valid;

  logic            r_pred_valid;
  logic            r_pred_hit;
  logic            r_pred_taken;
  logic [XLEN-1:0] r_pred_target;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  entry_t           w_lk_ent;
  logic             w_lk_hit;
  logic             w_lk_taken;

  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  entry_t           w_up_ent;
  logic             w_up_hit;
  logic             w_up_en;
  logic [CTR_W-1:0] w_up_ctr;
  logic             w_mis;

  assign w_lk_idx   = IDX_W'(btb_index(64'(bp.lookup_pc), IDX_W));
  assign w_lk_tag   = TAG_W'(btb_tag(64'(bp.lookup_pc), IDX_W));
  assign w_lk_ent   = r_tbl[w_lk_idx];
  assign w_lk_hit   = r_valid[w_lk_idx] && (w_lk_ent.tag == w_lk_tag);
  assign w_lk_taken = w_lk_hit && (w_lk_ent.is_jmp || w_lk_ent.ctr[CTR_W-1]);

  assign w_up_idx = IDX_W'(btb_index(64'(bp.upd_pc), IDX_W));
  assign w_up_tag = TAG_W'(btb_tag(64'(bp.upd_pc), IDX_W));
  assign w_up_ent = r_tbl[w_up_idx];
  assign w_up_hit = r_valid[w_up_idx] && (w_up_ent.tag == w_up_tag);
  assign w_up_en  = bp.upd_valid && !bp.stall;

  branch_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
    .i_ctr (w_up_ent.ctr),
    .i_inc (bp.upd_taken),
    .o_ctr (w_up_ctr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_valid  <= 1'b0;
      r_pred_hit    <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
    end else if (!bp.stall) begin
      if (bp.branch_squash || !bp.lookup_valid) begin
        r_pred_valid  <= 1'b0;
        r_pred_hit    <= 1'b0;
        r_pred_taken  <= 1'b0;
        r_pred_target <= '0;
      end else begin
        r_pred_valid  <= 1'b1;
        r_pred_hit    <= w_lk_hit;
        r_pred_taken  <= w_lk_taken;
        r_pred_target <= w_lk_taken ? w_lk_ent.target : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (bp.btb_flush) begin
      r_valid <= '0;
    end else if (w_up_en && !w_up_hit && bp.upd_taken) begin
      r_valid[w_up_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_up_en && !bp.btb_flush) begin
      if (w_up_hit) begin
        if (!w_up_ent.is_jmp) r_tbl[w_up_idx].ctr <= w_up_ctr;
        if (bp.upd_taken)     r_tbl[w_up_idx].target <= bp.upd_target;
      end else if (bp.upd_taken) begin
        r_tbl[w_up_idx] <= '{is_jmp: bp.upd_is_jmp, tag: w_up_tag,
                              target: bp.upd_target, ctr: CTR_INIT};
      end
    end
  end

  assign w_mis = w_up_en && ((bp.upd_taken != bp.upd_pred_taken) ||
                             (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));

  assign bp.mispredict  = w_mis;
  assign bp.redirect_pc = !w_mis        ? '0 :
                          bp.upd_taken  ? bp.upd_target :
                                          bp.upd_pc + XLEN'(4);

  assign bp.pred_valid  = r_pred_valid;
  assign bp.pred_hit    = r_pred_hit;
  assign bp.pred_taken  = r_pred_taken;
  assign bp.pred_target = r_pred_target;
endmodule

// File: tb/tb_branch_btb_predictor.sv
// Directed-vector bench for branch_btb_predictor (XLEN=32, ENTRIES=16, CTR_W=2).
module tb_branch_btb_predictor;
  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  branch_btb_predictor_if #(.XLEN(32)) bif ();

  branch_btb_predictor #(.XLEN(32), .ENTRIES(16), .CTR_W(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bif)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bif.stall = 0; bif.branch_squash = 0; bif.btb_flush = 0;
    bif.lookup_valid = 0; bif.lookup_pc = '0;
    bif.upd_valid = 0; bif.upd_pc = '0; bif.upd_is_jmp = 0; bif.upd_taken = 0;
    bif.upd_target = '0; bif.upd_pred_taken = 0; bif.upd_pred_target = '0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic jmp, input logic ptk, input logic [31:0] ptgt);
    bif.upd_valid = 1; bif.upd_pc = pc; bif.upd_taken = tk; bif.upd_target = tgt;
    bif.upd_is_jmp = jmp; bif.upd_pred_taken = ptk; bif.upd_pred_target = ptgt;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic jmp, input logic ptk, input logic [31:0] ptgt);
    @(negedge clk);
    set_upd(pc, tk, tgt, jmp, ptk, ptgt);
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic look(input logic [31:0] pc);
    @(negedge clk);
    bif.lookup_valid = 1; bif.lookup_pc = pc;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic exp_pred(input string tag, input logic v, input logic h, input logic t,
                          input logic [31:0] tgt);
    chk({tag, ".valid"},  32'(bif.pred_valid), 32'(v));
    chk({tag, ".hit"},    32'(bif.pred_hit),   32'(h));
    chk({tag, ".taken"},  32'(bif.pred_taken), 32'(t));
    chk({tag, ".target"}, bif.pred_target, tgt);
  endtask

  task automatic mp(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                    input logic ptk, input logic [31:0] ptgt, input logic emis, input logic [31:0] ered);
    @(negedge clk);
    set_upd(pc, tk, tgt, 1'b0, ptk, ptgt);
    #1;
    chk({tag, ".mispredict"}, 32'(bif.mispredict), 32'(emis));
    chk({tag, ".redirect"},   bif.redirect_pc, ered);
    @(posedge clk); #1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    exp_pred("reset", 0, 0, 0, 32'h0);
    @(negedge clk); rst_n = 1;

    // Cold miss, then allocate
    look(32'h100);                      exp_pred("cold_miss", 1, 0, 0, 32'h0);
    upd(32'h100, 1, 32'h200, 0, 0, 0);
    look(32'h100);                      exp_pred("cold_train", 1, 1, 1, 32'h200);

    // Counter saturation: 2 -> 1 -> 0 -> 0
    repeat (3) upd(32'h100, 0, 32'h0, 0, 1, 32'h200);
    look(32'h100);                      exp_pred("sat_low", 1, 1, 0, 32'h0);
    upd(32'h100, 1, 32'h200, 0, 0, 0);
    look(32'h100);                      exp_pred("ctr1", 1, 1, 0, 32'h0);
    repeat (3) upd(32'h100, 1, 32'h200, 0, 0, 0);
    look(32'h100);                      exp_pred("ctr3", 1, 1, 1, 32'h200);
    upd(32'h100, 1, 32'h200, 0, 1, 32'h200);
    upd(32'h100, 0, 32'h0, 0, 1, 32'h200);
    look(32'h100);                      exp_pred("sat_high_nt1", 1, 1, 1, 32'h200);
    upd(32'h100, 0, 32'h0, 0, 1, 32'h200);
    look(32'h100);                      exp_pred("sat_high_nt2", 1, 1, 0, 32'h0);

    // Aliasing: 0x140 shares index 0 with 0x100
    upd(32'h140, 1, 32'h280, 0, 0, 0);
    look(32'h100);                      exp_pred("alias_old", 1, 0, 0, 32'h0);
    look(32'h140);                      exp_pred("alias_new", 1, 1, 1, 32'h280);

    // Stall: predictions frozen, update and mispredict suppressed
    @(negedge clk);
    bif.stall = 1;
    set_upd(32'h140, 0, 32'h0, 0, 1, 32'h280);
    #1 chk("stall.mispredict_comb", 32'(bif.mispredict), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall.pred_valid",  32'(bif.pred_valid), 32'h1);
      chk("stall.pred_target", bif.pred_target, 32'h280);
      chk("stall.mispredict",  32'(bif.mispredict), 32'h0);
    end
    @(negedge clk);
    clear_inputs();
    @(posedge clk); #1;
    chk("idle.pred_valid",  32'(bif.pred_valid), 32'h0);
    chk("idle.pred_target", bif.pred_target, 32'h0);
    look(32'h140);                      exp_pred("post_stall", 1, 1, 1, 32'h280);

    // Squash
    @(negedge clk);
    bif.lookup_valid = 1; bif.lookup_pc = 32'h140; bif.branch_squash = 1;
    @(posedge clk); #1;
    clear_inputs();
    exp_pred("squash", 0, 0, 0, 32'h0);

    // Same-cycle lookup and update: read-before-write
    @(negedge clk);
    bif.lookup_valid = 1; bif.lookup_pc = 32'h140;
    set_upd(32'h140, 0, 32'h0, 0, 1, 32'h280);
    @(posedge clk); #1;
    clear_inputs();
    exp_pred("rbw_old", 1, 1, 1, 32'h280);
    look(32'h140);                      exp_pred("rbw_new", 1, 1, 0, 32'h0);
    upd(32'h140, 1, 32'h280, 0, 0, 0);

    // Flush wins over same-cycle update; same-cycle lookup sees old contents
    @(negedge clk);
    bif.btb_flush = 1;
    bif.lookup_valid = 1; bif.lookup_pc = 32'h140;
    set_upd(32'h180, 1, 32'h300, 0, 0, 0);
    @(posedge clk); #1;
    clear_inputs();
    exp_pred("flush_same", 1, 1, 1, 32'h280);
    look(32'h180);                      exp_pred("flush_upd", 1, 0, 0, 32'h0);
    look(32'h140);                      exp_pred("flush_old", 1, 0, 0, 32'h0);

    // Mispredict / redirect
    mp("mp_nt_pred",   32'h300, 1, 32'h340, 0, 32'h0,   1, 32'h340);
    mp("mp_t_pred",    32'h3FC, 0, 32'h500, 1, 32'h500, 1, 32'h400);
    mp("mp_correct",   32'h300, 1, 32'h340, 1, 32'h340, 0, 32'h0);
    mp("mp_badtgt",    32'h300, 1, 32'h340, 1, 32'h344, 1, 32'h340);
    mp("mp_nt_ok",     32'h300, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    mp("mp_wrap",      32'hFFFF_FFFC, 0, 32'h0, 1, 32'h10, 1, 32'h0);

    // Jump entries ignore not-taken training
    upd(32'h204, 1, 32'h800, 1, 0, 0);
    repeat (3) upd(32'h204, 0, 32'h999, 1, 1, 32'h800);
    look(32'h204);                      exp_pred("jmp_hold", 1, 1, 1, 32'h800);

    // Asynchronous reset mid-run
    upd(32'h100, 1, 32'h200, 0, 0, 0);
    look(32'h100);                      exp_pred("pre_reset", 1, 1, 1, 32'h200);
    @(negedge clk); rst_n = 0;
    #2;
    exp_pred("async_reset", 0, 0, 0, 32'h0);
    @(negedge clk); rst_n = 1;
    look(32'h100);                      exp_pred("post_reset", 1, 0, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
